// File: rtl/mul_arb_if.sv
// Purpose : request / issue / response bundle around the shared multiplier arbiter.
// Latency : wires only; timing is owned by the arbiter (slave side).
// Backpr. : reqN_ready is the only throttle; multiplier results cannot be stalled.
interface mul_arb_if #(
  parameter int XLEN                = 64,
  parameter int REG_FILE_ADDR_WIDTH = 4
);

  // Pipeline freeze from the core; blocks new grants only.
  logic                           freeze;

  // Requester 0.
  logic                           req0_valid;
  logic                           req0_ready;
  logic [XLEN-1:0]                req0_a;
  logic [XLEN-1:0]                req0_b;
  logic                           req0_rs1_sign;
  logic                           req0_rs2_sign;
  logic                           req0_low;
  logic [REG_FILE_ADDR_WIDTH-1:0] req0_rd_addr;

  // Requester 1.
  logic                           req1_valid;
  logic                           req1_ready;
  logic [XLEN-1:0]                req1_a;
  logic [XLEN-1:0]                req1_b;
  logic                           req1_rs1_sign;
  logic                           req1_rs2_sign;
  logic                           req1_low;
  logic [REG_FILE_ADDR_WIDTH-1:0] req1_rd_addr;

  // Registered issue towards the multiplier.
  logic                           mul_valid;
  logic [XLEN-1:0]                mul_a;
  logic [XLEN-1:0]                mul_b;
  logic                           mul_rs1_sign;
  logic                           mul_rs2_sign;
  logic                           mul_low;
  logic [REG_FILE_ADDR_WIDTH-1:0] mul_rd_addr;

  // Result coming back from the multiplier.
  logic                           mul_res_valid;
  logic [XLEN-1:0]                mul_res;
  logic [REG_FILE_ADDR_WIDTH-1:0] mul_res_rd_addr;

  // Response steered to the owning requester.
  logic                           rsp0_valid;
  logic                           rsp1_valid;
  logic [XLEN-1:0]                rsp_data;
  logic [REG_FILE_ADDR_WIDTH-1:0] rsp_rd_addr;

  // Status.
  logic                           busy;
  logic                           err;

  // Arbiter side.
  modport slave (
    input  freeze,
    input  req0_valid, req0_a, req0_b, req0_rs1_sign, req0_rs2_sign, req0_low, req0_rd_addr,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low, req1_rd_addr,
    output req1_ready,
    output mul_valid, mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low, mul_rd_addr,
    input  mul_res_valid, mul_res, mul_res_rd_addr,
    output rsp0_valid, rsp1_valid, rsp_data, rsp_rd_addr,
    output busy, err
  );

  // Requesters plus multiplier side.
  modport master (
    output freeze,
    output req0_valid, req0_a, req0_b, req0_rs1_sign, req0_rs2_sign, req0_low, req0_rd_addr,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_rs1_sign, req1_rs2_sign, req1_low, req1_rd_addr,
    input  req1_ready,
    input  mul_valid, mul_a, mul_b, mul_rs1_sign, mul_rs2_sign, mul_low, mul_rd_addr,
    output mul_res_valid, mul_res, mul_res_rd_addr,
    input  rsp0_valid, rsp1_valid, rsp_data, rsp_rd_addr,
    input  busy, err
  );

endinterface

// File: rtl/mul_arb.sv
// Purpose : arbitrates two multiply requesters onto one pipelined multiplier and routes results back.
// Latency : issue registered 1 cycle after transfer; response MUL_LAT+1 cycles after transfer.
// Backpr. : combinational grant on reqN_ready; freeze or a losing tie holds a requester off.
// Config  : define MUL_ARB_RR_EN for round-robin tie-break; default build is fixed priority (req 0 wins).
module mul_arb #(
  parameter int XLEN                = 64,
  parameter int REG_FILE_ADDR_WIDTH = 4,
  parameter int MUL_LAT             = 3    // must be >= 1
) (
  input  logic     clk,
  input  logic     rstn,
  mul_arb_if.slave bus
);

  // One tracker stage per cycle between transfer and result; head lines up with mul_res_valid.
  localparam int DEPTH = MUL_LAT + 1;

  logic                           gnt0;
  logic                           gnt1;
  logic                           fire;

  logic                           iss_valid;
  logic [XLEN-1:0]                iss_a;
  logic [XLEN-1:0]                iss_b;
  logic                           iss_rs1_sign;
  logic                           iss_rs2_sign;
  logic                           iss_low;
  logic [REG_FILE_ADDR_WIDTH-1:0] iss_rd_addr;

  // Owner tracker: bit 0 is loaded with the issue, bit DEPTH-1 is the head.
  logic [DEPTH-1:0]               trk_vld;
  logic [DEPTH-1:0]               trk_id;
  logic                           head_vld;
  logic                           head_id;

  logic                           err_q;

`ifdef MUL_ARB_RR_EN
  // Last requester granted; reset to 1 so requester 0 takes the first tie.
  logic                           last_gnt;
`endif

  // Grant selection: nothing under freeze, lone requester wins, ties by pointer or fixed priority.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!bus.freeze) begin
      if (bus.req0_valid && bus.req1_valid) begin
`ifdef MUL_ARB_RR_EN
        gnt0 = last_gnt;
        gnt1 = !last_gnt;
`else
        gnt0 = 1'b1;
`endif
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  // A grant is only ever given to a valid requester, so grant equals transfer.
  assign fire           = gnt0 | gnt1;
  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

`ifdef MUL_ARB_RR_EN
  // Pointer moves only when a transfer actually completes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_gnt <= 1'b1;
    end else if (fire) begin
      last_gnt <= gnt1;
    end
  end
`endif

  // Issue register: capture the winner's fields; payload holds when nothing is issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      iss_valid    <= 1'b0;
      iss_a        <= '0;
      iss_b        <= '0;
      iss_rs1_sign <= 1'b0;
      iss_rs2_sign <= 1'b0;
      iss_low      <= 1'b0;
      iss_rd_addr  <= '0;
    end else begin
      iss_valid <= fire;
      if (gnt0) begin
        iss_a        <= bus.req0_a;
        iss_b        <= bus.req0_b;
        iss_rs1_sign <= bus.req0_rs1_sign;
        iss_rs2_sign <= bus.req0_rs2_sign;
        iss_low      <= bus.req0_low;
        iss_rd_addr  <= bus.req0_rd_addr;
      end else if (gnt1) begin
        iss_a        <= bus.req1_a;
        iss_b        <= bus.req1_b;
        iss_rs1_sign <= bus.req1_rs1_sign;
        iss_rs2_sign <= bus.req1_rs2_sign;
        iss_low      <= bus.req1_low;
        iss_rd_addr  <= bus.req1_rd_addr;
      end
    end
  end

  assign bus.mul_valid    = iss_valid;
  assign bus.mul_a        = iss_a;
  assign bus.mul_b        = iss_b;
  assign bus.mul_rs1_sign = iss_rs1_sign;
  assign bus.mul_rs2_sign = iss_rs2_sign;
  assign bus.mul_low      = iss_low;
  assign bus.mul_rd_addr  = iss_rd_addr;

  // Owner tracker shifts every cycle regardless of freeze; the multiplier never stalls.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      trk_vld <= '0;
      trk_id  <= '0;
    end else begin
      trk_vld <= {trk_vld[DEPTH-2:0], fire};
      trk_id  <= {trk_id[DEPTH-2:0], gnt1};
    end
  end

  assign head_vld = trk_vld[DEPTH-1];
  assign head_id  = trk_id[DEPTH-1];

  // Result steering: only a result that matches a tracked issue is delivered.
  assign bus.rsp0_valid  = bus.mul_res_valid && head_vld && !head_id;
  assign bus.rsp1_valid  = bus.mul_res_valid && head_vld &&  head_id;
  assign bus.rsp_data    = bus.mul_res;
  assign bus.rsp_rd_addr = bus.mul_res_rd_addr;

  // Sticky error on any disagreement between the multiplier and the tracker head.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (bus.mul_res_valid != head_vld) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err  = err_q;
  assign bus.busy = iss_valid | (|trk_vld);

  // Grants are one-hot-or-zero and only to a requester that is asking.
  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rstn) !(gnt0 && gnt1));
  a_gnt0_valid : assert property (@(posedge clk) disable iff (!rstn) !gnt0 || bus.req0_valid);
  a_gnt1_valid : assert property (@(posedge clk) disable iff (!rstn) !gnt1 || bus.req1_valid);

  // The first tracker stage is the issue register's shadow.
  a_trk_align  : assert property (@(posedge clk) disable iff (!rstn) trk_vld[0] == iss_valid);

endmodule

// File: tb/tb_mul_arb.sv
// Purpose : self-checking bench for mul_arb with a behavioural pipelined multiplier.
// Latency : expects each response MUL_LAT+1 cycles after its transfer.
// Backpr. : expected grants are hand-listed per step; responses checked by a scoreboard monitor.
module tb_mul_arb;

  localparam int XLEN    = 64;
  localparam int RFA     = 4;
  localparam int MUL_LAT = 3;

  typedef struct {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            s1;
    logic            s2;
    logic            low;
    logic [RFA-1:0]  rd;
    logic [XLEN-1:0] res;
  } vec_t;

  typedef struct {
    int              owner;
    logic [XLEN-1:0] data;
    logic [RFA-1:0]  rd;
    int              cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mul_arb_if #(.XLEN(XLEN), .REG_FILE_ADDR_WIDTH(RFA)) bus ();

  mul_arb #(.XLEN(XLEN), .REG_FILE_ADDR_WIDTH(RFA), .MUL_LAT(MUL_LAT)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rsp_seen = 0;
  int   i0       = 0;
  int   i1       = 0;
  logic inject   = 1'b0;
  vec_t tab0[8];
  vec_t tab1[8];
  exp_t sb[$];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: captures mul_* and returns the result MUL_LAT cycles later.
  function automatic logic [XLEN-1:0] mul_model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                                input logic s1, input logic s2, input logic low);
    logic [2*XLEN-1:0] ea;
    logic [2*XLEN-1:0] eb;
    logic [2*XLEN-1:0] p;
    ea = {{XLEN{s1 & a[XLEN-1]}}, a};
    eb = {{XLEN{s2 & b[XLEN-1]}}, b};
    p  = ea * eb;
    return low ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  logic [MUL_LAT-1:0] pv;
  logic [XLEN-1:0]    pd [MUL_LAT];
  logic [RFA-1:0]     pr [MUL_LAT];

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pv <= '0;
    end else begin
      pv    <= {pv[MUL_LAT-2:0], bus.mul_valid};
      pd[0] <= mul_model(bus.mul_a, bus.mul_b, bus.mul_rs1_sign, bus.mul_rs2_sign, bus.mul_low);
      pr[0] <= bus.mul_rd_addr;
      for (int i = 1; i < MUL_LAT; i++) begin
        pd[i] <= pd[i-1];
        pr[i] <= pr[i-1];
      end
    end
  end

  assign bus.mul_res_valid   = pv[MUL_LAT-1] | inject;
  assign bus.mul_res         = pd[MUL_LAT-1];
  assign bus.mul_res_rd_addr = pr[MUL_LAT-1];

  task automatic check_w(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, act, req);
    end
  endtask

  task automatic check_i(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic s1,
                              input logic s2, input logic low, input logic [RFA-1:0] rd,
                              input logic [XLEN-1:0] res);
    vec_t v;
    v.a = a; v.b = b; v.s1 = s1; v.s2 = s2; v.low = low; v.rd = rd; v.res = res;
    return v;
  endfunction

  // Monitor: every presented response must be the oldest expected one, on its cycle.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.rsp0_valid || bus.rsp1_valid) begin
        rsp_seen++;
        check_b("rsp_onehot", bus.rsp0_valid & bus.rsp1_valid, 1'b0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_orphan: got rsp0=%b rsp1=%b data=%0h, required no response",
                   bus.rsp0_valid, bus.rsp1_valid, bus.rsp_data);
        end else begin
          mon_e = sb.pop_front();
          check_i("rsp_owner", int'(bus.rsp1_valid), mon_e.owner);
          check_w("rsp_data", bus.rsp_data, mon_e.data);
          check_i("rsp_rd_addr", int'(bus.rsp_rd_addr), int'(mon_e.rd));
          check_i("rsp_cycle", cyc, mon_e.cyc);
        end
      end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
        mon_e = sb.pop_front();
        n_checks++;
        n_fail++;
        $display("FAIL rsp_missing: got nothing by cycle %0d, required owner %0d data %0h at cycle %0d",
                 cyc, mon_e.owner, mon_e.data, mon_e.cyc);
      end
    end
  end

  // One cycle of stimulus: drive, check grants (and optionally mul_valid), push expected responses.
  task automatic step(input logic v0, input logic v1, input logic frz, input logic e0, input logic e1,
                      input int mv, input string tag);
    exp_t t;
    bus.req0_valid    = v0;
    bus.req1_valid    = v1;
    bus.freeze        = frz;
    bus.req0_a        = tab0[i0].a;
    bus.req0_b        = tab0[i0].b;
    bus.req0_rs1_sign = tab0[i0].s1;
    bus.req0_rs2_sign = tab0[i0].s2;
    bus.req0_low      = tab0[i0].low;
    bus.req0_rd_addr  = tab0[i0].rd;
    bus.req1_a        = tab1[i1].a;
    bus.req1_b        = tab1[i1].b;
    bus.req1_rs1_sign = tab1[i1].s1;
    bus.req1_rs2_sign = tab1[i1].s2;
    bus.req1_low      = tab1[i1].low;
    bus.req1_rd_addr  = tab1[i1].rd;
    @(negedge clk);
    check_b({tag, "_req0_ready"}, bus.req0_ready, e0);
    check_b({tag, "_req1_ready"}, bus.req1_ready, e1);
    if (mv >= 0) check_b({tag, "_mul_valid"}, bus.mul_valid, mv[0]);
    if (e0) begin
      t.owner = 0; t.data = tab0[i0].res; t.rd = tab0[i0].rd; t.cyc = cyc + MUL_LAT + 1;
      sb.push_back(t);
      i0 = (i0 + 1) % 8;
    end
    if (e1) begin
      t.owner = 1; t.data = tab1[i1].res; t.rd = tab1[i1].rd; t.cyc = cyc + MUL_LAT + 1;
      sb.push_back(t);
      i1 = (i1 + 1) % 8;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1, "idle");
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.freeze     = 1'b0;
    repeat (2) @(posedge clk);
    sb.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

`ifdef MUL_ARB_RR_EN
  localparam logic [3:0] T3_G0 = 4'b0101;
`else
  localparam logic [3:0] T3_G0 = 4'b1111;
`endif

  initial begin
    logic [3:0] g0;
    int         snap;
    g0 = T3_G0;

    tab0[0] = mk(64'd6, 64'd7, 1'b0, 1'b0, 1'b1, 4'd3, 64'd42);
    tab0[1] = mk(64'd3, 64'd5, 1'b0, 1'b0, 1'b1, 4'd1, 64'd15);
    tab0[2] = mk(64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 1'b0, 1'b0, 4'd2, 64'd1);
    tab0[3] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 1'b0, 4'd4, 64'd0);
    tab0[4] = mk(64'd100, 64'd100, 1'b0, 1'b0, 1'b1, 4'd5, 64'd10000);
    tab0[5] = mk(64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 1'b1, 1'b1, 1'b1, 4'd6, 64'hFFFF_FFFF_FFFF_FFF1);
    tab0[6] = mk(64'h8000_0000_0000_0000, 64'd2, 1'b0, 1'b0, 1'b0, 4'd7, 64'd1);
    tab0[7] = mk(64'd12, 64'd12, 1'b0, 1'b0, 1'b1, 4'd8, 64'd144);
    tab1[0] = mk(64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 1'b1, 1'b1, 1'b1, 4'd9, 64'hFFFF_FFFF_FFFF_FFF8);
    tab1[1] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b0, 4'd10, 64'd1);
    tab1[2] = mk(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b1, 1'b0, 1'b0, 4'd11, 64'hFFFF_FFFF_FFFF_FFFF);
    tab1[3] = mk(64'd7, 64'd9, 1'b0, 1'b0, 1'b1, 4'd12, 64'd63);
    tab1[4] = mk(64'd0, 64'd123, 1'b0, 1'b0, 1'b1, 4'd13, 64'd0);
    tab1[5] = mk(64'hFFFF_FFFF, 64'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 4'd14, 64'hFFFF_FFFE_0000_0001);
    tab1[6] = mk(64'd11, 64'd11, 1'b0, 1'b0, 1'b1, 4'd15, 64'd121);
    tab1[7] = mk(64'd1000, 64'd3, 1'b0, 1'b0, 1'b1, 4'd0, 64'd3000);

    rstn = 1'b0;
    bus.freeze = 1'b0;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state.
    check_b("rst_mul_valid", bus.mul_valid, 1'b0);
    check_b("rst_busy", bus.busy, 1'b0);
    check_b("rst_err", bus.err, 1'b0);
    check_b("rst_rsp0", bus.rsp0_valid, 1'b0);
    check_b("rst_rsp1", bus.rsp1_valid, 1'b0);
    check_w("rst_mul_a", bus.mul_a, '0);
    check_i("rst_mul_rd", int'(bus.mul_rd_addr), 0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Single request: 6*7 -> 42 to rd 3, issue next cycle, response 4 cycles after transfer.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, "t2");
    bus.req0_valid = 1'b0;
    @(negedge clk);
    check_b("t2_mul_valid", bus.mul_valid, 1'b1);
    check_w("t2_mul_a", bus.mul_a, 64'd6);
    check_w("t2_mul_b", bus.mul_b, 64'd7);
    check_b("t2_mul_low", bus.mul_low, 1'b1);
    check_i("t2_mul_rd", int'(bus.mul_rd_addr), 3);
    check_b("t2_busy", bus.busy, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_b("t2_mul_valid_pulse", bus.mul_valid, 1'b0);
    check_w("t2_mul_a_hold", bus.mul_a, 64'd6);
    @(posedge clk);
    #1;
    idle(4);
    check_b("t2_busy_drained", bus.busy, 1'b0);
    check_b("t2_err", bus.err, 1'b0);

    // Both requesters valid four cycles straight after reset.
    do_reset();
    for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b0, g0[k], ~g0[k], (k == 0) ? 0 : 1, "t3");
    idle(6);
    check_i("t3_drained", sb.size(), 0);
    check_b("t3_err", bus.err, 1'b0);

    // Freeze with both valid: no grants, but in-flight results still reach their owners.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, "t4_pre1");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1, "t4_pre0");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1, "t4_frz1");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "t4_frz2");
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, "t4_frz3");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "t4_post");
    idle(5);
    check_i("t4_drained", sb.size(), 0);
    check_b("t4_err", bus.err, 1'b0);

    // Reset with three ops in flight, then an orphan result.
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, "t5_a");
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -1, "t5_b");
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1, "t5_c");
    check_b("t5_busy_pre", bus.busy, 1'b1);
    rstn = 1'b0;
    bus.req0_valid = 1'b0;
    #1;
    check_b("t5_busy_rst", bus.busy, 1'b0);
    check_b("t5_mul_valid_rst", bus.mul_valid, 1'b0);
    sb.delete();
    snap = rsp_seen;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    idle(8);
    check_i("t5_no_rsp_after_rst", rsp_seen, snap);
    check_b("t5_err_before", bus.err, 1'b0);
    inject = 1'b1;
    @(negedge clk);
    check_b("t5_orphan_rsp0", bus.rsp0_valid, 1'b0);
    check_b("t5_orphan_rsp1", bus.rsp1_valid, 1'b0);
    @(posedge clk);
    #1;
    inject = 1'b0;
    @(negedge clk);
    check_b("t5_err_set", bus.err, 1'b1);
    @(posedge clk);
    #1;
    idle(5);
    check_b("t5_err_sticky", bus.err, 1'b1);
    check_b("t5_busy_end", bus.busy, 1'b0);
    check_i("end_sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by time %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
